// File: rtl/intel_pcie_tlp_pkg.sv
// Shared TLP definitions for the register completer: fmt/type codes,
// completion status codes, header layout and a completion header builder.
package intel_pcie_tlp_pkg;

  // Combined {fmt[2:0], type[4:0]} codes as found in DW0[31:24]
  localparam logic [7:0] MRD32 = 8'b000_00000;
  localparam logic [7:0] MWR32 = 8'b010_00000;
  localparam logic [7:0] CPL   = 8'b000_01010;
  localparam logic [7:0] CPLD  = 8'b010_01010;

  // Completion status codes
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  // Every request served is a single DW, so byte count is always 4
  localparam logic [11:0] CPL_BYTE_COUNT = 12'd4;

  // Unused 32-bit words in a 256-bit (8 DW) beat
  localparam logic [2:0] EMPTY_3DW = 3'd5;
  localparam logic [2:0] EMPTY_4DW = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2
  } state_t;

  // 3/4-DW header as it sits in the low 128 bits of a beat (DW0 at bit 0)
  typedef struct packed {
    logic [31:0] dw3;
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } tlp_hdr_t;

  // Assemble a completion header; DW3 carries the payload (zero for Cpl)
  function automatic tlp_hdr_t build_cpl(
    input logic [7:0]  fmt_type,
    input logic [2:0]  tc,
    input logic [9:0]  length,
    input logic [15:0] completer_id,
    input logic [2:0]  status,
    input logic [15:0] requester_id,
    input logic [7:0]  tag,
    input logic [6:0]  lower_addr,
    input logic [31:0] payload
  );
    tlp_hdr_t h;
    // fmt/type, T9, TC, T8/attr/LN/TH, TD/EP, attr, AT, length
    h.dw0 = {fmt_type, 1'b0, tc, 4'b0000, 2'b00, 2'b00, 2'b00, length};
    // completer ID, status, BCM, byte count
    h.dw1 = {completer_id, status, 1'b0, CPL_BYTE_COUNT};
    // requester ID, tag, reserved, lower address
    h.dw2 = {requester_id, tag, 1'b0, lower_addr};
    h.dw3 = payload;
    return h;
  endfunction

endpackage

// File: rtl/intel_pcie_tlp_completer_if.sv
// Avalon-ST request sink and completion source of the TLP completer.
// The slave modport is the completer side, master is the link side.
interface intel_pcie_tlp_completer_if;

  // Request TLP stream into the completer
  logic [255:0] tlp_rx_st_data;
  logic [2:0]   tlp_rx_st_empty;
  logic         tlp_rx_st_startofpacket;
  logic         tlp_rx_st_endofpacket;
  logic         tlp_rx_st_error;
  logic         tlp_rx_st_valid;
  logic         tlp_rx_st_ready;

  // Completion TLP stream out of the completer
  logic [255:0] tlp_tx_st_data;
  logic [2:0]   tlp_tx_st_empty;
  logic         tlp_tx_st_startofpacket;
  logic         tlp_tx_st_endofpacket;
  logic         tlp_tx_st_valid;
  logic         tlp_tx_st_ready;

  modport slave (
    input  tlp_rx_st_data,
    input  tlp_rx_st_empty,
    input  tlp_rx_st_startofpacket,
    input  tlp_rx_st_endofpacket,
    input  tlp_rx_st_error,
    input  tlp_rx_st_valid,
    output tlp_rx_st_ready,
    output tlp_tx_st_data,
    output tlp_tx_st_empty,
    output tlp_tx_st_startofpacket,
    output tlp_tx_st_endofpacket,
    output tlp_tx_st_valid,
    input  tlp_tx_st_ready
  );

  modport master (
    output tlp_rx_st_data,
    output tlp_rx_st_empty,
    output tlp_rx_st_startofpacket,
    output tlp_rx_st_endofpacket,
    output tlp_rx_st_error,
    output tlp_rx_st_valid,
    input  tlp_rx_st_ready,
    input  tlp_tx_st_data,
    input  tlp_tx_st_empty,
    input  tlp_tx_st_startofpacket,
    input  tlp_tx_st_endofpacket,
    input  tlp_tx_st_valid,
    output tlp_tx_st_ready
  );

endinterface

// File: rtl/intel_pcie_tlp_completer_regfile.sv
// Bank of NUM_REGS 32-bit registers with per-byte write enables and an
// asynchronous read port; every byte clears to zero on reset.
module intel_pcie_tlp_completer_regfile
  import intel_pcie_tlp_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] words [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] word;
      for (genvar bi = 0; bi < 4; bi++) begin : g_byte
        logic [7:0] byte_reg;
        // Byte lane update: only the addressed register with its BE bit set
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            byte_reg <= 8'h00;
          end else if (wr_en && (wr_idx == IDX_W'(gi)) && wr_be[bi]) begin
            byte_reg <= wr_data[8*bi +: 8];
          end
        end
        assign word[8*bi +: 8] = byte_reg;
      end
      assign words[gi] = word;
    end
  endgenerate

  // Read is combinational so the completer can capture it on SOP accept
  assign rd_data = words[rd_idx];

endmodule

// File: rtl/intel_pcie_tlp_completer.sv
// Register-file completer: accepts MWr32/MRd32 on a 256-bit request stream,
// writes registers, and answers reads with a single-beat CplD (or Cpl/UR).
module intel_pcie_tlp_completer
  import intel_pcie_tlp_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [15:0]                 completer_id,
  intel_pcie_tlp_completer_if.slave   tlp,
  output logic [15:0]                 unsupported_count
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_t         state_reg;
  state_t         state_next;
  logic           pending_reg;
  logic [255:0]   tx_data_reg;
  logic [2:0]     tx_empty_reg;
  logic [15:0]    count_reg;

  // Header fields of the current beat; only meaningful on an SOP beat
  tlp_hdr_t       rx_hdr;
  logic [7:0]     rx_fmt_type;
  logic [2:0]     rx_tc;
  logic           rx_ep;
  logic [9:0]     rx_length;
  logic [15:0]    rx_requester_id;
  logic [7:0]     rx_tag;
  logic [3:0]     rx_first_be;
  logic [31:0]    rx_addr;
  logic [31:0]    rx_payload;
  logic [IDX_W-1:0] reg_idx;

  logic           ready_state;
  logic           rx_ready;
  logic           rx_accept;
  logic           sop_accept;
  logic           good_wr;
  logic           is_rd;
  logic           good_rd;
  logic           wr_en;
  logic           drop;
  logic [31:0]    rd_data;
  tlp_hdr_t       cpl_hdr;
  logic [2:0]     cpl_empty;
  logic           unused_bits;

  assign rx_hdr          = tlp_hdr_t'(tlp.tlp_rx_st_data[127:0]);
  assign rx_fmt_type     = rx_hdr.dw0[31:24];
  assign rx_tc           = rx_hdr.dw0[22:20];
  assign rx_ep           = rx_hdr.dw0[14];
  assign rx_length       = rx_hdr.dw0[9:0];
  assign rx_requester_id = rx_hdr.dw1[31:16];
  assign rx_tag          = rx_hdr.dw1[15:8];
  assign rx_first_be     = rx_hdr.dw1[3:0];
  assign rx_addr         = rx_hdr.dw2;
  assign rx_payload      = rx_hdr.dw3;
  // Higher address bits alias onto the register bank
  assign reg_idx         = rx_addr[IDX_W+1:2];

  // Bits of the beat this completer never looks at
  assign unused_bits = ^{tlp.tlp_rx_st_data[255:128], rx_hdr, tlp.tlp_rx_st_empty};

  // Sink is held off while reset is asserted, regardless of state
  assign rx_ready   = reset_n & ready_state;
  assign rx_accept  = tlp.tlp_rx_st_valid & rx_ready;
  // Only an SOP beat seen in IDLE starts a request; anything else is drained
  assign sop_accept = rx_accept & tlp.tlp_rx_st_startofpacket & (state_reg == IDLE);

  assign good_wr = !tlp.tlp_rx_st_error && (rx_fmt_type == MWR32) &&
                   (rx_length == 10'd1) && !rx_ep;
  assign is_rd   = !tlp.tlp_rx_st_error && (rx_fmt_type == MRD32);
  assign good_rd = is_rd && (rx_length == 10'd1);
  assign wr_en   = sop_accept & good_wr;
  // Dropped requests and UR-answered reads both count as unsupported
  assign drop    = sop_accept & !good_wr & !good_rd;

  intel_pcie_tlp_completer_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_idx   (reg_idx),
    .wr_be    (rx_first_be),
    .wr_data  (rx_payload),
    .rd_idx   (reg_idx),
    .rd_data  (rd_data)
  );

  // Completion header formed from the SOP beat; read data captured here
  always_comb begin
    cpl_hdr = build_cpl(
      good_rd ? CPLD : CPL,
      rx_tc,
      good_rd ? 10'd1 : 10'd0,
      completer_id,
      good_rd ? CPL_SC : CPL_UR,
      rx_requester_id,
      rx_tag,
      {rx_addr[6:2], 2'b00},
      good_rd ? rd_data : 32'h0000_0000
    );
    cpl_empty = good_rd ? EMPTY_4DW : EMPTY_3DW;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next  = state_reg;
    ready_state = 1'b0;
    unique case (state_reg)
      IDLE: begin
        ready_state = 1'b1;
        if (sop_accept) begin
          if (!tlp.tlp_rx_st_endofpacket) begin
            state_next = DRAIN;
          end else if (is_rd) begin
            state_next = RESP;
          end
        end
      end
      DRAIN: begin
        ready_state = 1'b1;
        if (rx_accept && tlp.tlp_rx_st_endofpacket) begin
          state_next = pending_reg ? RESP : IDLE;
        end
      end
      RESP: begin
        if (tlp.tlp_tx_st_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and completion-due flag for multi-beat requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (sop_accept) begin
        pending_reg <= is_rd;
      end
    end
  end

  // Completion beat is frozen at SOP accept so it stays stable under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_reg  <= '0;
      tx_empty_reg <= 3'd0;
    end else if (sop_accept && is_rd) begin
      tx_data_reg  <= {128'b0, cpl_hdr};
      tx_empty_reg <= cpl_empty;
    end
  end

  // Saturating unsupported-request counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 16'h0000;
    end else if (drop && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'h0001;
    end
  end

  assign tlp.tlp_rx_st_ready         = rx_ready;
  assign tlp.tlp_tx_st_valid         = (state_reg == RESP);
  assign tlp.tlp_tx_st_startofpacket = (state_reg == RESP);
  assign tlp.tlp_tx_st_endofpacket   = (state_reg == RESP);
  assign tlp.tlp_tx_st_data          = tx_data_reg;
  assign tlp.tlp_tx_st_empty         = tx_empty_reg;
  assign unsupported_count           = count_reg;

endmodule

// File: tb/tb_intel_pcie_tlp_completer.sv
// Directed self-checking bench for the TLP register completer.
module tb_intel_pcie_tlp_completer;

  logic        clk;
  logic        reset_n;
  logic [15:0] completer_id;
  logic [15:0] unsupported_count;

  int n_checks;
  int n_fails;

  intel_pcie_tlp_completer_if bus ();

  intel_pcie_tlp_completer #(
    .NUM_REGS (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .completer_id      (completer_id),
    .tlp               (bus),
    .unsupported_count (unsupported_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request beat builder: requester ID fixed at 0x0100
  function automatic logic [255:0] mk_req(
    input logic [7:0]  ft,
    input logic [2:0]  tc,
    input logic        ep,
    input logic [9:0]  len,
    input logic [7:0]  tag,
    input logic [3:0]  be,
    input logic [31:0] addr,
    input logic [31:0] pay
  );
    logic [31:0] dw0;
    logic [31:0] dw1;
    dw0 = {ft, 1'b0, tc, 4'b0000, 1'b0, ep, 4'b0000, len};
    dw1 = {16'h0100, tag, 4'b0000, be};
    return {128'b0, pay, addr, dw1, dw0};
  endfunction

  // Present one beat at posedge+1 and hold it until accepted; returns at accept+1
  task automatic send_beat(input logic [255:0] d, input logic sop, input logic eop,
                           input logic err);
    int n;
    bus.tlp_rx_st_data          = d;
    bus.tlp_rx_st_empty         = 3'd4;
    bus.tlp_rx_st_startofpacket = sop;
    bus.tlp_rx_st_endofpacket   = eop;
    bus.tlp_rx_st_error         = err;
    bus.tlp_rx_st_valid         = 1'b1;
    n = 0;
    while (bus.tlp_rx_st_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fails++;
      $display("FAIL rx_accept_timeout: ready=%b after %0d cycles, want 1", bus.tlp_rx_st_ready, n);
    end
    @(posedge clk);
    #1;
    $display("[%0t] beat sop=%b eop=%b err=%b dw0=%h dw1=%h dw2=%h dw3=%h", $time, sop, eop, err,
             d[31:0], d[63:32], d[95:64], d[127:96]);
    bus.tlp_rx_st_valid         = 1'b0;
    bus.tlp_rx_st_startofpacket = 1'b0;
    bus.tlp_rx_st_endofpacket   = 1'b0;
    bus.tlp_rx_st_error         = 1'b0;
  endtask

  task automatic test_reset;
    #22;
    n_checks++;
    if (bus.tlp_rx_st_ready !== 1'b0) begin
      n_fails++; $display("FAIL reset_rx_ready: got %b want 0", bus.tlp_rx_st_ready);
    end
    n_checks++;
    if ({bus.tlp_tx_st_valid, bus.tlp_tx_st_startofpacket, bus.tlp_tx_st_endofpacket} !== 3'b000) begin
      n_fails++; $display("FAIL reset_tx_flags: got %b%b%b want 000", bus.tlp_tx_st_valid,
                          bus.tlp_tx_st_startofpacket, bus.tlp_tx_st_endofpacket);
    end
    n_checks++;
    if (bus.tlp_tx_st_data !== 256'h0 || bus.tlp_tx_st_empty !== 3'd0) begin
      n_fails++; $display("FAIL reset_tx_data: got %h/%0d want 0/0", bus.tlp_tx_st_data, bus.tlp_tx_st_empty);
    end
    n_checks++;
    if (unsupported_count !== 16'h0000) begin
      n_fails++; $display("FAIL reset_count: got %h want 0000", unsupported_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.tlp_rx_st_ready !== 1'b1) begin
      n_fails++; $display("FAIL release_rx_ready: got %b want 1", bus.tlp_rx_st_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    logic [255:0] exp;
    send_beat(mk_req(8'h40, 3'd0, 1'b0, 10'd1, 8'h00, 4'hF, 32'h8, 32'hDEADBEEF), 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b0 || unsupported_count !== 16'd0) begin
      n_fails++; $display("FAIL mwr_no_cpl: valid=%b count=%0d want 0/0", bus.tlp_tx_st_valid, unsupported_count);
    end
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h12, 4'hF, 32'h8, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'hDEADBEEF, 32'h01001208, 32'hABCD0004, 32'h4A000001};
    n_checks++;
    if ({bus.tlp_tx_st_valid, bus.tlp_tx_st_startofpacket, bus.tlp_tx_st_endofpacket} !== 3'b111) begin
      n_fails++; $display("FAIL cpld_flags: got %b%b%b want 111", bus.tlp_tx_st_valid,
                          bus.tlp_tx_st_startofpacket, bus.tlp_tx_st_endofpacket);
    end
    n_checks++;
    if (bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL cpld_data: got %h want %h", bus.tlp_tx_st_data, exp);
    end
    n_checks++;
    if (bus.tlp_tx_st_empty !== 3'd4 || bus.tlp_rx_st_ready !== 1'b0) begin
      n_fails++; $display("FAIL cpld_empty_ready: empty=%0d ready=%b want 4/0", bus.tlp_tx_st_empty, bus.tlp_rx_st_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b0 || bus.tlp_rx_st_ready !== 1'b1) begin
      n_fails++; $display("FAIL cpld_handshake: valid=%b ready=%b want 0/1", bus.tlp_tx_st_valid, bus.tlp_rx_st_ready);
    end
  endtask

  task automatic test_byte_enable;
    logic [255:0] exp;
    send_beat(mk_req(8'h40, 3'd0, 1'b0, 10'd1, 8'h00, 4'hF, 32'h4, 32'h11223344), 1'b1, 1'b1, 1'b0);
    send_beat(mk_req(8'h40, 3'd0, 1'b0, 10'd1, 8'h00, 4'h3, 32'h4, 32'hAABBCCDD), 1'b1, 1'b1, 1'b0);
    send_beat(mk_req(8'h00, 3'd5, 1'b0, 10'd1, 8'h34, 4'hF, 32'h4, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'h1122CCDD, 32'h01003404, 32'hABCD0004, 32'h4A500001};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL be_merge: valid=%b got %h want %h", bus.tlp_tx_st_valid, bus.tlp_tx_st_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    logic [255:0] exp;
    exp = {128'b0, 32'hDEADBEEF, 32'h01005608, 32'hABCD0004, 32'h4A000001};
    bus.tlp_tx_st_ready = 1'b0;
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h56, 4'hF, 32'h8, 32'h0), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_rx_st_ready !== 1'b0 || bus.tlp_tx_st_data !== exp ||
          bus.tlp_tx_st_empty !== 3'd4 || bus.tlp_tx_st_startofpacket !== 1'b1 || bus.tlp_tx_st_endofpacket !== 1'b1) begin
        n_fails++; $display("FAIL stall_cycle%0d: valid=%b ready=%b empty=%0d data=%h want 1/0/4 %h", i,
                            bus.tlp_tx_st_valid, bus.tlp_rx_st_ready, bus.tlp_tx_st_empty, bus.tlp_tx_st_data, exp);
      end
      @(posedge clk);
      #1;
    end
    bus.tlp_tx_st_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b0 || bus.tlp_rx_st_ready !== 1'b1) begin
      n_fails++; $display("FAIL stall_release: valid=%b ready=%b want 0/1", bus.tlp_tx_st_valid, bus.tlp_rx_st_ready);
    end
  endtask

  task automatic test_ur;
    logic [255:0] exp;
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd2, 8'h77, 4'hF, 32'h8, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'h00000000, 32'h01007708, 32'hABCD2004, 32'h0A000000};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL ur_data: valid=%b got %h want %h", bus.tlp_tx_st_valid, bus.tlp_tx_st_data, exp);
    end
    n_checks++;
    if (bus.tlp_tx_st_empty !== 3'd5 || unsupported_count !== 16'd1) begin
      n_fails++; $display("FAIL ur_empty_count: empty=%0d count=%0d want 5/1", bus.tlp_tx_st_empty, unsupported_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drop;
    logic [255:0] exp;
    // two-beat CfgRd: dropped, counted once
    send_beat(mk_req(8'h04, 3'd0, 1'b0, 10'd1, 8'h22, 4'hF, 32'h8, 32'h0), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b0 || bus.tlp_rx_st_ready !== 1'b1 || unsupported_count !== 16'd2) begin
      n_fails++; $display("FAIL cfgrd_sop: valid=%b ready=%b count=%0d want 0/1/2", bus.tlp_tx_st_valid,
                          bus.tlp_rx_st_ready, unsupported_count);
    end
    send_beat(256'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b0 || unsupported_count !== 16'd2) begin
      n_fails++; $display("FAIL cfgrd_eop: valid=%b count=%0d want 0/2", bus.tlp_tx_st_valid, unsupported_count);
    end
    // stray non-SOP beat in IDLE: discarded silently, no write
    send_beat(mk_req(8'h40, 3'd0, 1'b0, 10'd1, 8'h00, 4'hF, 32'h8, 32'h55555555), 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (unsupported_count !== 16'd2) begin
      n_fails++; $display("FAIL stray_beat_count: got %0d want 2", unsupported_count);
    end
    // MWr with error, with EP, with length 2: each dropped and counted
    send_beat(mk_req(8'h40, 3'd0, 1'b0, 10'd1, 8'h00, 4'hF, 32'h8, 32'h55555555), 1'b1, 1'b1, 1'b1);
    send_beat(mk_req(8'h40, 3'd0, 1'b1, 10'd1, 8'h00, 4'hF, 32'h8, 32'h66666666), 1'b1, 1'b1, 1'b0);
    send_beat(mk_req(8'h40, 3'd0, 1'b0, 10'd2, 8'h00, 4'hF, 32'h8, 32'h77777777), 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (unsupported_count !== 16'd5 || bus.tlp_tx_st_valid !== 1'b0) begin
      n_fails++; $display("FAIL bad_mwr_count: count=%0d valid=%b want 5/0", unsupported_count, bus.tlp_tx_st_valid);
    end
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h21, 4'hF, 32'h8, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'hDEADBEEF, 32'h01002108, 32'hABCD0004, 32'h4A000001};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL after_drop_read: valid=%b got %h want %h", bus.tlp_tx_st_valid, bus.tlp_tx_st_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [255:0] exp;
    // high address bits ignored: 0x48 selects register 2 (same as 0x8)
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h99, 4'hF, 32'h48, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'hDEADBEEF, 32'h01009948, 32'hABCD0004, 32'h4A000001};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL alias_read: valid=%b got %h want %h", bus.tlp_tx_st_valid, bus.tlp_tx_st_data, exp);
    end
    // next request offered while the completion is still out
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h02, 4'hF, 32'h0, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'h00000000, 32'h01000200, 32'hABCD0004, 32'h4A000001};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp || unsupported_count !== 16'd5) begin
      n_fails++; $display("FAIL b2b_read: valid=%b count=%0d got %h want %h", bus.tlp_tx_st_valid,
                          unsupported_count, bus.tlp_tx_st_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [255:0] exp;
    bus.tlp_tx_st_ready = 1'b0;
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h31, 4'hF, 32'h8, 32'h0), 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1) begin
      n_fails++; $display("FAIL pending_before_reset: valid=%b want 1", bus.tlp_tx_st_valid);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b0 || bus.tlp_rx_st_ready !== 1'b0 || bus.tlp_tx_st_data !== 256'h0 ||
        unsupported_count !== 16'd0) begin
      n_fails++; $display("FAIL mid_reset: valid=%b ready=%b count=%0d data=%h want 0/0/0/0", bus.tlp_tx_st_valid,
                          bus.tlp_rx_st_ready, unsupported_count, bus.tlp_tx_st_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.tlp_tx_st_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.tlp_rx_st_ready !== 1'b1 || bus.tlp_tx_st_valid !== 1'b0) begin
      n_fails++; $display("FAIL mid_release: ready=%b valid=%b want 1/0", bus.tlp_rx_st_ready, bus.tlp_tx_st_valid);
    end
    @(posedge clk);
    #1;
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h40, 4'hF, 32'h8, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'h00000000, 32'h01004008, 32'hABCD0004, 32'h4A000001};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL cleared_reg8: valid=%b got %h want %h", bus.tlp_tx_st_valid, bus.tlp_tx_st_data, exp);
    end
    @(posedge clk);
    #1;
    send_beat(mk_req(8'h00, 3'd0, 1'b0, 10'd1, 8'h41, 4'hF, 32'h4, 32'h0), 1'b1, 1'b1, 1'b0);
    exp = {128'b0, 32'h00000000, 32'h01004104, 32'hABCD0004, 32'h4A000001};
    n_checks++;
    if (bus.tlp_tx_st_valid !== 1'b1 || bus.tlp_tx_st_data !== exp) begin
      n_fails++; $display("FAIL cleared_reg4: valid=%b got %h want %h", bus.tlp_tx_st_valid, bus.tlp_tx_st_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    completer_id = 16'hABCD;
    bus.tlp_rx_st_data          = '0;
    bus.tlp_rx_st_empty         = 3'd0;
    bus.tlp_rx_st_startofpacket = 1'b0;
    bus.tlp_rx_st_endofpacket   = 1'b0;
    bus.tlp_rx_st_error         = 1'b0;
    bus.tlp_rx_st_valid         = 1'b0;
    bus.tlp_tx_st_ready         = 1'b1;

    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_ur();
    test_drop();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
